// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the key-schedule stages.
package aes_pkg;

  typedef logic [127:0] key_t;

  typedef enum logic [0:0] {
    ModeIdle,
    ModeEmit
  } mode_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by the 4-bit round counter; entries 0 and 11..15 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One reverse AES-128 key-schedule step: round-r key plus Rcon[r] -> round r-1 key.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  key_t       key_i,
  input  logic [7:0] rcon_i,
  output key_t       key_o
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_rot;

  assign k0 = key_i[31:0];
  assign k1 = key_i[63:32];
  assign k2 = key_i[95:64];
  assign k3 = key_i[127:96];

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // Leading byte sits in bits [7:0], so RotWord moves it to the top byte.
  assign sub_rot = {SBOX[p3[7:0]], SBOX[p3[31:24]], SBOX[p3[23:16]], SBOX[p3[15:8]]};

  assign p0 = k0 ^ sub_rot ^ {24'h000000, rcon_i};

  assign key_o = {p3, p2, p1, p0};

endmodule

// File: rtl/inv_expand_key_128.sv
// Reverse AES-128 key-schedule walker: pops a round-10 key, pushes rounds 10..0.
// Optional INV_KEY_MIX_COLUMNS_EN emits InvMixColumns(key) for rounds 9..1.
module inv_expand_key_128
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] in_key,
  output logic         in_key_rd,
  input  logic         in_key_empty,
  output logic [127:0] out_key,
  output logic         out_key_wr,
  input  logic         out_key_full
);

  mode_e      mode_q, mode_d;
  logic [3:0] rnd_q, rnd_d;
  key_t       kreg_q, kreg_d;
  key_t       prev_key;

  aes_inv_key_step u_step (
    .key_i  (kreg_q),
    .rcon_i (RCON[rnd_q]),
    .key_o  (prev_key)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= ModeIdle;
      rnd_q  <= 4'd0;
      kreg_q <= '0;
    end else begin
      mode_q <= mode_d;
      rnd_q  <= rnd_d;
      kreg_q <= kreg_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    rnd_d      = rnd_q;
    kreg_d     = kreg_q;
    in_key_rd  = 1'b0;
    out_key_wr = 1'b0;
    unique case (mode_q)
      ModeIdle: begin
        in_key_rd = !in_key_empty;
        if (!in_key_empty) begin
          kreg_d = in_key;
          rnd_d  = 4'd10;
          mode_d = ModeEmit;
        end
      end
      ModeEmit: begin
        out_key_wr = !out_key_full;
        if (!out_key_full) begin
          if (rnd_q != 4'd0) begin
            kreg_d = prev_key;
            rnd_d  = rnd_q - 4'd1;
          end else if (!in_key_empty) begin
            // Overlap the next pop with the final write so schedules run back to back.
            in_key_rd = 1'b1;
            kreg_d    = in_key;
            rnd_d     = 4'd10;
          end else begin
            mode_d = ModeIdle;
          end
        end
      end
      default: mode_d = ModeIdle;
    endcase
    if (reset) begin
      in_key_rd  = 1'b0;
      out_key_wr = 1'b0;
    end
  end

`ifdef INV_KEY_MIX_COLUMNS_EN
  function automatic key_t inv_mix_columns(input key_t k);
    key_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = k[32*c +: 8];
      a1 = k[32*c + 8 +: 8];
      a2 = k[32*c + 16 +: 8];
      a3 = k[32*c + 24 +: 8];
      r[32*c +: 8]      = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[32*c + 8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  logic mid_round;
  assign mid_round = (mode_q == ModeEmit) && (rnd_q != 4'd0) && (rnd_q != 4'd10);

  always_comb begin
    out_key = kreg_q;
    if (mid_round) out_key = inv_mix_columns(kreg_q);
  end
`else
  assign out_key = kreg_q;
`endif

endmodule

// File: tb/tb_inv_expand_key_128.sv
// Self-checking bench for inv_expand_key_128 with independent forward key-schedule model.
module tb_inv_expand_key_128;

  typedef logic [127:0] sched_t [11];
  typedef struct {
    logic [127:0] ck;
    logic [127:0] r10;
    logic [127:0] r9;
    logic [127:0] r0;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_key = '0;
  logic         in_key_rd;
  logic         in_key_empty = 1'b1;
  logic [127:0] out_key;
  logic         out_key_wr;
  logic         out_key_full = 1'b0;

  int total = 0;
  int bad = 0;

  logic [127:0] src_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] wr_log[$];
  logic [7:0]   sb [256];
  logic         rd_seen = 1'b0;
  vec_t         vt [4];

  always #5 clock = ~clock;

  inv_expand_key_128 dut (
    .clock        (clock),
    .reset        (reset),
    .in_key       (in_key),
    .in_key_rd    (in_key_rd),
    .in_key_empty (in_key_empty),
    .out_key      (out_key),
    .out_key_wr   (out_key_wr),
    .out_key_full (out_key_full)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] imc(input logic [127:0] k);
    logic [127:0] r = '0;
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = k[32*c + 8*j +: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gm(a[j], m[(j - i + 4) % 4]);
        r[32*c + 8*i +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] emit_exp(input logic [127:0] k, input int r);
`ifdef INV_KEY_MIX_COLUMNS_EN
    if (r >= 1 && r <= 9) return imc(k);
`endif
    return k;
  endfunction

  task automatic expand(input logic [127:0] ck, output sched_t rk);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = ck[32*j +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[7:0] = t[7:0] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  task automatic refresh();
    in_key_empty = (src_q.size() == 0);
    in_key = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic push_key(input logic [127:0] ck, output sched_t rk);
    expand(ck, rk);
    src_q.push_back(rk[10]);
    for (int r = 10; r >= 0; r--) exp_q.push_back(emit_exp(rk[r], r));
    refresh();
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (wr_log.size() < n && c < budget) begin
      sample();
      c++;
    end
    check("write_timeout", 128'(wr_log.size() >= n), 128'd1);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      sample();
      c++;
    end
    check("drain_left", 128'(exp_q.size()), 128'd0);
  endtask

  // Downstream FIFO and scoreboard: a write seen here lands on the next rising edge.
  always @(negedge clock) begin
    rd_seen <= !reset && in_key_rd;
    if (reset) begin
      check("strobe_in_reset", {126'b0, out_key_wr, in_key_rd}, 128'd0);
    end else begin
      check("rd_on_empty", 128'(in_key_rd & in_key_empty), 128'd0);
      check("wr_on_full", 128'(out_key_wr & out_key_full), 128'd0);
      if (out_key_wr) begin
        wr_log.push_back(out_key);
        if (exp_q.size() == 0) check("extra_wr", 128'(out_key_wr), 128'd0);
        else check("wr_key", out_key, exp_q.pop_front());
      end
    end
  end

  // Upstream FIFO: retire the head after a pop edge.
  always @(posedge clock) begin
    #1;
    if (rd_seen && src_q.size() != 0) void'(src_q.pop_front());
    refresh();
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    sched_t rk;
    logic [127:0] hold;
    logic [7:0] r;

    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      repeat (254) r = gm(r, 8'(x));
      sb[x] = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    end

    vt[0].ck  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    vt[0].r10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    vt[0].r9  = emit_exp(128'h6e005c574129d12821dcfa19f36677ac, 9);
    vt[0].r0  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    vt[1].ck  = '0;
    vt[2].ck  = '1;
    vt[3].ck  = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 1; i < 4; i++) begin
      expand(vt[i].ck, rk);
      vt[i].r10 = rk[10];
      vt[i].r9  = emit_exp(rk[9], 9);
      vt[i].r0  = rk[0];
    end

    repeat (3) step();
    reset = 1'b0;

    // Empty input after reset.
    for (int i = 0; i < 20; i++) begin
      sample();
      check("idle_rd", 128'(in_key_rd), 128'd0);
      check("idle_wr", 128'(out_key_wr), 128'd0);
      check("idle_key", out_key, 128'd0);
    end

    // Table of single-key schedules.
    for (int i = 0; i < 4; i++) begin
      step();
      wr_log.delete();
      push_key(vt[i].ck, rk);
      wait_writes(11, 40);
      if (wr_log.size() >= 11) begin
        check($sformatf("vec%0d_r10", i), wr_log[0], vt[i].r10);
        check($sformatf("vec%0d_r9", i), wr_log[1], vt[i].r9);
        check($sformatf("vec%0d_r0", i), wr_log[10], vt[i].r0);
      end
      sample();
      check($sformatf("vec%0d_back_idle_wr", i), 128'(out_key_wr), 128'd0);
      check($sformatf("vec%0d_sb_empty", i), 128'(exp_q.size()), 128'd0);
    end

    // Back-to-back keys: 22 consecutive writes, second pop on the 11th write.
    step();
    push_key(128'h00112233445566778899aabbccddeeff, rk);
    push_key(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, rk);
    for (int c = 0; c < 20 && !out_key_wr; c++) sample();
    for (int i = 0; i < 22; i++) begin
      if (i > 0) sample();
      check($sformatf("b2b_wr%0d", i), 128'(out_key_wr), 128'd1);
      if (i == 10) check("b2b_second_pop", 128'(in_key_rd), 128'd1);
    end
    sample();
    check("b2b_end_wr", 128'(out_key_wr), 128'd0);
    wait_drain(10);

    // Backpressure at round 6.
    step();
    wr_log.delete();
    push_key(128'hdeadbeef0123456789abcdeffedcba98, rk);
    wait_writes(4, 30);
    step();
    out_key_full = 1'b1;
    hold = emit_exp(rk[6], 6);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_wr", 128'(out_key_wr), 128'd0);
      check("bp_key", out_key, hold);
    end
    step();
    out_key_full = 1'b0;
    wait_writes(11, 40);
    wait_drain(10);

    // Reset after the fourth write, with the next key already queued.
    step();
    wr_log.delete();
    push_key(128'h13579bdf02468ace1122334455667788, rk);
    wait_writes(4, 30);
    step();
    reset = 1'b1;
    exp_q.delete();
    push_key(128'h8899aabbccddeeff0011223344556677, rk);
    sample();
    check("rst_wr", 128'(out_key_wr), 128'd0);
    check("rst_rd", 128'(in_key_rd), 128'd0);
    step();
    reset = 1'b0;
    sample();
    check("post_rst_key", out_key, 128'd0);
    check("post_rst_wr", 128'(out_key_wr), 128'd0);
    wait_writes(15, 40);
    if (wr_log.size() >= 5) check("restart_r10", wr_log[4], rk[10]);
    wait_drain(10);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_expand_key_128.md
# inv_expand_key_128

Reverse AES-128 key-schedule walker for the decryption side of the AES accelerator kernel. It pops one last-round key (round 10) from an upstream FIFO. It then emits that key and every earlier round key, down to round 0, into a downstream FIFO, one key per accepted write. It uses the same 128-bit rd/empty and wr/full FIFO handshake as the forward key-expansion stages, running in the opposite direction of the schedule.

## Interface
- No parameters; fixed at AES-128, 10 rounds.
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_key  input  128  round-10 key; byte k at bits [k*8 +: 8], byte 0 is the first AES byte
- in_key_rd  output  1  pop strobe to the upstream FIFO
- in_key_empty  input  1  upstream FIFO empty
- out_key  output  128  current round key, same byte order as in_key
- out_key_wr  output  1  push strobe to the downstream FIFO
- out_key_full  input  1  downstream FIFO full

## Operation
- State: mode register {IDLE, EMIT}, 4-bit round counter rnd, 128-bit key register kreg.
- Word j of a key is bytes 4j..4j+3; byte 4j is the leading byte.
- IDLE behaviour:
  - in_key_rd = !in_key_empty.
  - On a pop: kreg <= in_key, rnd <= 10, go to EMIT.
- EMIT behaviour:
  - out_key is driven from kreg, passed through the optional output transform (see Configuration).
  - out_key_wr = !out_key_full.
  - If no write occurs, hold all state.
- On a write with rnd != 0, apply the inverse step with Rcon[rnd] and decrement rnd:
  - p3 = k3 ^ k2; p2 = k2 ^ k1; p1 = k1 ^ k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[rnd], 00, 00, 00}.
  - RotWord [a0, a1, a2, a3] -> [a1, a2, a3, a0].
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36; all XORs are bitwise over 8-bit bytes.
- On a write with rnd == 0 (last key), branch on in_key_empty:
  - If !in_key_empty: in_key_rd = 1 in the same cycle, kreg <= in_key, rnd <= 10, stay in EMIT (back-to-back keys).
  - Otherwise: in_key_rd = 0, go to IDLE.
- in_key_rd is 0 in EMIT except in the final-write overlap case above.

## Timing
- Reset values:
  - mode IDLE, rnd 0, kreg 0.
  - out_key_wr 0; out_key = 0 (in the untransformed path).
  - in_key_rd follows !in_key_empty from the first post-reset cycle.
- Latency: the round-10 key is available on out_key in the cycle after the pop.
- Throughput: 11 writes per input key. With back-to-back inputs and no backpressure, one write per cycle and a new pop every 11 cycles.
- out_key_full stalls at any round: rnd and kreg are unchanged, out_key is stable, and out_key_wr stays 0.
- Reset asserted mid-sequence aborts the sequence:
  - No further writes.
  - The partially emitted schedule is discarded.
  - No pop is issued in the reset cycle.
- Handshake strobes are combinational from the FIFO flags. No pop occurs on empty; no push occurs on full.

## Configuration
- INV_KEY_MIX_COLUMNS_EN defined:
  - out_key for rounds 9..1 is InvMixColumns(kreg), applied per word as a column with the 0e/0b/0d/09 matrix over GF(2^8), reduction polynomial 11b.
  - Rounds 10 and 0 are emitted untransformed.
  - kreg recurrence is unaffected.
  - This gives the equivalent-inverse-cipher key set.
- INV_KEY_MIX_COLUMNS_EN undefined: out_key = kreg for every round; no GF logic is instantiated.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry S-box constant;
  - the Rcon[1..10] constant array;
  - the mode enum;
  - a 128-bit key typedef;
  - the xtime/gmul helper functions used by InvMixColumns.
- One sub-module, aes_inv_key_step: combinational (kreg, Rcon) -> previous-round key, containing the four S-box lookups. It is reusable by a future fully unrolled variant.

## Test plan
- FIPS-197 key check, macro off:
  - Stimulus: push in_key = 128'ha60c63b6c80c3fe18925eec9a8f914d0 (round 10).
  - First write: the same value.
  - Second write: 128'h6e005c574129d12821dcfa19f36677ac (round 9).
  - 11th write: 128'h3c4fcf098815f7aba6d2ae2816157e2b (cipher key).
  - Then the block returns to IDLE.
- Back-to-back keys:
  - Stimulus: two keys queued, out_key_full = 0.
  - Expect exactly 22 consecutive write cycles.
  - Second pop coincides with the 11th write; no idle cycle between the two schedules.
- Backpressure:
  - Stimulus: hold out_key_full = 1 for 5 cycles while rnd = 6.
  - Expect out_key_wr = 0 and out_key stable throughout.
  - After release, the remaining sequence is unchanged.
- Empty input:
  - Stimulus: in_key_empty = 1 for 20 cycles after reset.
  - Expect in_key_rd = 0, out_key_wr = 0, out_key = 0.
- Reset mid-run:
  - Stimulus: assert reset after the 4th write.
  - Expect no write in the reset cycle or after it.
  - Next pushed key restarts from round 10.
- INV_KEY_MIX_COLUMNS_EN defined, same FIPS key:
  - Rounds 10 and 0 match the macro-off vectors.
  - Round 9 equals InvMixColumns of 128'h6e005c574129d12821dcfa19f36677ac, checked against a reference model.
